// File: rtl/mux_e_2_1_if.sv
// Signal bundle for mux_e_2_1: data/select/enable in, combinational and registered results out.
// No handshake: the master may change inputs at any time; the slave captures whatever is present at each rising clk.
interface mux_e_2_1_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             s0;
    logic             e;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             y_vld;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output i0, i1, s0, e,
        input  y, y_q, y_vld, chg_cnt
    );

    modport slave (
        input  i0, i1, s0, e,
        output y, y_q, y_vld, chg_cnt
    );
endinterface

// File: rtl/mux_e_2_1.sv
// Enabled 2:1 mux with a combinational output, a registered copy, and a saturating
// counter of clock edges on which the registered copy changed value.
module mux_e_2_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    mux_e_2_1_if.slave bus
);
    logic [WIDTH-1:0] y_comb;

    // A ?: on an unknown select merges agreeing bits and leaves the rest X.
    assign y_comb = bus.e ? (bus.s0 ? bus.i1 : bus.i0) : '0;
    assign bus.y  = y_comb;

    logic [WIDTH-1:0] y_q_r;
    logic             y_vld_r;
    logic [CNT_W-1:0] chg_cnt_r;

    // Reset value of y_q_r is the change baseline, so the first nonzero capture counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_r     <= '0;
            y_vld_r   <= 1'b0;
            chg_cnt_r <= '0;
        end else begin
            y_q_r   <= y_comb;
            y_vld_r <= bus.e;
            if ((y_comb != y_q_r) && (chg_cnt_r != {CNT_W{1'b1}}))
                chg_cnt_r <= chg_cnt_r + CNT_W'(1);
        end
    end

    assign bus.y_q     = y_q_r;
    assign bus.y_vld   = y_vld_r;
    assign bus.chg_cnt = chg_cnt_r;
endmodule

// File: tb/tb_mux_e_2_1.sv
// Bench for mux_e_2_1: three instances (1-bit truth table, 8-bit registered stage,
// 2-bit counter saturation) checked through an expected-value scoreboard.
module tb_mux_e_2_1;
    logic clk = 1'b0;
    logic rst1, rst8, rst_s;

    always #5 clk = ~clk;

    mux_e_2_1_if #(.WIDTH(1), .CNT_W(8)) b1 ();
    mux_e_2_1_if #(.WIDTH(8), .CNT_W(8)) b8 ();
    mux_e_2_1_if #(.WIDTH(8), .CNT_W(2)) bs ();

    mux_e_2_1 #(.WIDTH(1), .CNT_W(8)) u_w1  (.clk(clk), .rst(rst1),  .bus(b1.slave));
    mux_e_2_1 #(.WIDTH(8), .CNT_W(8)) u_w8  (.clk(clk), .rst(rst8),  .bus(b8.slave));
    mux_e_2_1 #(.WIDTH(8), .CNT_W(2)) u_sat (.clk(clk), .rst(rst_s), .bus(bs.slave));

    // Scoreboard: expected value, which output to compare, and a label.
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        chk_req = 1'b0;

    localparam int K_W1_Y   = 0;
    localparam int K_W8_Y   = 1;
    localparam int K_W8_YQ  = 2;
    localparam int K_W8_VLD = 3;
    localparam int K_W8_CNT = 4;
    localparam int K_S_CNT  = 5;
    localparam int K_S_YQ   = 6;

    task automatic push_exp(input int k, input logic [31:0] v, input string nm);
        kind_q.push_back(k);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic check_now();
        chk_req = ~chk_req;
        #1;
    endtask

    // Monitor: drains the queue whenever the driver presents a settled output.
    always begin
        logic [31:0] exp_v, got;
        int          k;
        string       nm;
        @(chk_req);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            k     = kind_q.pop_front();
            nm    = name_q.pop_front();
            case (k)
                K_W1_Y:   got = 32'(b1.y);
                K_W8_Y:   got = 32'(b8.y);
                K_W8_YQ:  got = 32'(b8.y_q);
                K_W8_VLD: got = 32'(b8.y_vld);
                K_W8_CNT: got = 32'(b8.chg_cnt);
                K_S_CNT:  got = 32'(bs.chg_cnt);
                K_S_YQ:   got = 32'(bs.y_q);
                default:  got = 32'hDEAD_BEEF;
            endcase
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp_v, $time);
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] tt;
        logic [7:0]  sat_yq [5];
        int          sat_cnt[5];
        tt      = 16'hCA00;  // index {e,s0,i1,i0}
        sat_yq  = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        sat_cnt = '{1, 2, 3, 3, 3};

        rst1 = 1'b1; rst8 = 1'b1; rst_s = 1'b1;
        b1.i0 = '0; b1.i1 = '0; b1.s0 = 1'b0; b1.e = 1'b0;
        b8.i0 = '0; b8.i1 = '0; b8.s0 = 1'b0; b8.e = 1'b0;
        bs.i0 = '0; bs.i1 = '0; bs.s0 = 1'b0; bs.e = 1'b0;

        // Truth-table sequence on the 1-bit instance (held in reset: y must not care).
        #1; push_exp(K_W1_Y, 32'd0, "tt_start"); check_now();
        #8; b1.i0 = 1'b1;
        #1; push_exp(K_W1_Y, 32'd0, "tt_i0_disabled"); check_now();
        #8; b1.s0 = 1'b1; b1.e = 1'b1;
        #1; push_exp(K_W1_Y, 32'd0, "tt_i1_selected"); check_now();
        #8; b1.i1 = 1'b1;
        #1; push_exp(K_W1_Y, 32'd1, "tt_i1_high"); check_now();

        for (int c = 0; c < 16; c++) begin
            {b1.e, b1.s0, b1.i1, b1.i0} = c[3:0];
            #1;
            push_exp(K_W1_Y, 32'(tt[c]), $sformatf("sweep_%0d", c));
            check_now();
        end

        // Registered stage, 8-bit: reset values first.
        push_exp(K_W8_YQ, 32'h0, "rst_yq");
        push_exp(K_W8_VLD, 32'h0, "rst_vld");
        push_exp(K_W8_CNT, 32'h0, "rst_cnt");
        check_now();

        @(negedge clk);
        rst8 = 1'b0;
        b8.e = 1'b1; b8.s0 = 1'b0; b8.i0 = 8'hA5; b8.i1 = 8'h3C;
        #1; push_exp(K_W8_Y, 32'hA5, "comb_a5"); check_now();
        after_edge();
        push_exp(K_W8_YQ, 32'hA5, "e1_yq");
        push_exp(K_W8_VLD, 32'h1, "e1_vld");
        push_exp(K_W8_CNT, 32'd1, "e1_cnt");
        check_now();

        @(negedge clk); b8.s0 = 1'b1;
        #1; push_exp(K_W8_Y, 32'h3C, "comb_3c"); push_exp(K_W8_YQ, 32'hA5, "yq_before_edge"); check_now();
        after_edge();
        push_exp(K_W8_YQ, 32'h3C, "e2_yq");
        push_exp(K_W8_CNT, 32'd2, "e2_cnt");
        check_now();

        repeat (2) after_edge();
        push_exp(K_W8_YQ, 32'h3C, "hold_yq");
        push_exp(K_W8_CNT, 32'd2, "hold_cnt");
        check_now();

        // Asynchronous reset between edges.
        @(negedge clk); #1; rst8 = 1'b1; #1;
        push_exp(K_W8_YQ, 32'h0, "arst_yq");
        push_exp(K_W8_VLD, 32'h0, "arst_vld");
        push_exp(K_W8_CNT, 32'h0, "arst_cnt");
        push_exp(K_W8_Y, 32'h3C, "arst_y");
        check_now();
        after_edge();
        push_exp(K_W8_YQ, 32'h0, "arst_held_yq");
        push_exp(K_W8_CNT, 32'h0, "arst_held_cnt");
        push_exp(K_W8_Y, 32'h3C, "arst_held_y");
        check_now();

        @(negedge clk); rst8 = 1'b0;
        after_edge();
        push_exp(K_W8_YQ, 32'h3C, "post_rst_yq");
        push_exp(K_W8_VLD, 32'h1, "post_rst_vld");
        push_exp(K_W8_CNT, 32'd1, "post_rst_cnt");
        check_now();

        @(negedge clk); b8.s0 = 1'b0;
        after_edge();
        push_exp(K_W8_YQ, 32'hA5, "pre_dis_yq");
        push_exp(K_W8_CNT, 32'd2, "pre_dis_cnt");
        check_now();

        @(negedge clk); b8.e = 1'b0;
        #1; push_exp(K_W8_Y, 32'h0, "dis_y"); check_now();
        after_edge();
        push_exp(K_W8_YQ, 32'h0, "dis_yq");
        push_exp(K_W8_VLD, 32'h0, "dis_vld");
        push_exp(K_W8_CNT, 32'd3, "dis_cnt");
        check_now();

        // Saturation with a 2-bit counter.
        @(negedge clk);
        rst_s = 1'b0;
        bs.e = 1'b1; bs.s0 = 1'b0; bs.i0 = 8'hA5; bs.i1 = 8'h3C;
        for (int n = 0; n < 5; n++) begin
            after_edge();
            push_exp(K_S_YQ, 32'(sat_yq[n]), $sformatf("sat_yq_%0d", n));
            push_exp(K_S_CNT, 32'(sat_cnt[n]), $sformatf("sat_cnt_%0d", n));
            check_now();
            @(negedge clk); bs.s0 = ~bs.s0;
        end

        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_e_2_1.md
# mux_e_2_1

Two-input multiplexer with active-high enable, parameterised data width, plus a registered output stage and an output-change counter. The combinational path (Y) is the primary function and works with no clock running. The registered side (Y_Q, Y_VLD, CHG_CNT) gives downstream synchronous logic a glitch-free copy of the selected data and a simple activity monitor.

## Interface
- WIDTH, 1, data width of I0, I1, Y, Y_Q.
- CNT_W, 8, width of the change counter CHG_CNT.

- CLK  input  1  rising-edge clock for the registered stage.
- RST  input  1  reset, asynchronous and active-high; clears all registered outputs.
- I0  input  WIDTH  data input 0, selected when S0=0.
- I1  input  WIDTH  data input 1, selected when S0=1.
- S0  input  1  select.
- E  input  1  enable, active-high.
- Y  output  WIDTH  combinational mux output.
- Y_Q  output  WIDTH  Y registered on CLK.
- Y_VLD  output  1  E registered on CLK.
- CHG_CNT  output  CNT_W  count of clock edges on which Y_Q changed value; saturating.

## Operation
- Y = E ? (S0 ? I1 : I0) : 0 (all bits zero when disabled).
- Y is purely combinational.
  - No dependence on CLK or RST.
  - Settles within the same delta time as any input change.
- X/Z on S0 while E=1: Y bits where I0 and I1 agree take that value; other bits are X.
- E=0 forces Y to 0 regardless of S0, I0 or I1 (including X/Z on them).
- Registered stage, each rising CLK edge with RST=0:
  - Y_Q <= Y.
  - Y_VLD <= E.
  - If the new Y_Q differs from the current Y_Q, CHG_CNT increments by 1.
  - CHG_CNT saturates at all-ones and does not wrap.
  - CHG_CNT holds when Y_Q does not change.
- A disabled-to-enabled transition alone does not count; only a change in Y_Q value counts.
- With WIDTH>1, any differing bit counts as one change per edge, not one per bit.

## Timing
- Y: zero-cycle, combinational.
- Y_Q, Y_VLD: one-cycle latency from inputs to output.
- CHG_CNT: updates on the same edge that Y_Q changes.
- RST asserted, asynchronously and at any time (including mid-operation):
  - Y_Q=0, Y_VLD=0, CHG_CNT=0 immediately.
  - All three held there while RST=1.
- RST deassertion:
  - First capture occurs on the next rising CLK edge.
  - The reset value Y_Q=0 is the comparison baseline, so a first captured nonzero Y counts as one change.
- RST has no effect on Y.
- No handshake; inputs may change at any time. Only values present at the CLK edge are captured.

## Test plan
- Truth table, clockless, WIDTH=1, sequence of input changes:
  - Start: I0=0, I1=0, S0=0, E=0 -> Y=0.
  - t=10: I0=1 -> Y=0 (disabled).
  - t=20: S0=1, E=1 -> Y=0 (I1 selected).
  - t=30: I1=1 -> Y=1.
- Exhaustive sweep, WIDTH=1: all 16 combinations of I0, I1, S0, E.
  - Y equals I0 for E=1, S0=0.
  - Y equals I1 for E=1, S0=1.
  - Y=0 whenever E=0.
- Registered stage, WIDTH=8:
  - Stimulus: E=1, S0=0, I0=8'hA5, I1=8'h3C, then S0=1 before the next edge.
  - After edge 1: Y_Q=8'hA5, Y_VLD=1, CHG_CNT=1.
  - After edge 2: Y_Q=8'h3C, CHG_CNT=2.
  - Holding inputs for further edges keeps CHG_CNT=2.
- Async reset mid-operation:
  - Assert RST between clock edges while CHG_CNT=2 and Y_Q=8'h3C.
  - Y_Q, Y_VLD and CHG_CNT go to 0 before the next edge.
  - Y stays 8'h3C throughout.
- Saturation, CNT_W=2, toggle S0 each cycle with I0≠I1:
  - CHG_CNT goes 1, 2, 3, then stays 3.
- Disable: E toggles 1->0 while Y_Q=8'hA5.
  - Next edge: Y_Q=0, Y_VLD=0, CHG_CNT increments once.
